// File: rtl/filter_buf_pkg.sv
// Shared types and defaults for the filter-weight stream buffer.
package filter_buf_pkg;

    localparam int unsigned DefWordW     = 32;
    localparam int unsigned DefElemW     = 8;
    localparam int unsigned DefFiltElems = 16;

    typedef enum logic [1:0] {
        BankEmpty   = 2'd0,
        BankFilling = 2'd1,
        BankLoaded  = 2'd2
    } bank_state_e;

    function automatic int unsigned words_per_filter(input int unsigned word_w,
                                                     input int unsigned elem_w,
                                                     input int unsigned filt_elems);
        return (filt_elems * elem_w) / word_w;
    endfunction

endpackage

// File: rtl/filter_bank.sv
// One filter's worth of weight storage: word-wide write port, element-wide combinational read.
module filter_bank
    import filter_buf_pkg::*;
#(
    parameter int unsigned WORD_W     = DefWordW,
    parameter int unsigned ELEM_W     = DefElemW,
    parameter int unsigned FILT_ELEMS = DefFiltElems,
    parameter int unsigned WORDS      = 4,
    parameter int unsigned WPTR_W     = 2,
    parameter int unsigned PTR_W      = 4
) (
    input  logic              clk_i,
    input  logic              wr_en_i,
    input  logic [WPTR_W-1:0] wr_addr_i,
    input  logic [WORD_W-1:0] wr_data_i,
    input  logic [PTR_W-1:0]  rd_ptr_i,
    output logic [ELEM_W-1:0] rd_elem_o
);

    localparam int unsigned TOT_W = FILT_ELEMS * ELEM_W;

    logic [WORD_W-1:0] mem_q [WORDS];
    logic [TOT_W-1:0]  flat;
    logic [ELEM_W-1:0] elems [FILT_ELEMS];

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Word 0 lands in the MSBs so element 0 is the MSB element of the first word.
    always_comb begin
        flat = '0;
        for (int unsigned w = 0; w < WORDS; w++) begin
            flat[(WORDS-1-w)*WORD_W +: WORD_W] = mem_q[w];
        end
    end

    always_comb begin
        for (int unsigned e = 0; e < FILT_ELEMS; e++) begin
            elems[e] = flat[(FILT_ELEMS-1-e)*ELEM_W +: ELEM_W];
        end
    end

    assign rd_elem_o = elems[rd_ptr_i];

endmodule

// File: rtl/filter_stream_buffer.sv
// Filter-weight buffer: word loads, auto-rewinding element readout, explicit release.
// Define FILTER_STREAM_BUFFER_PINGPONG_EN for two-bank ping-pong operation.
module filter_stream_buffer
    import filter_buf_pkg::*;
#(
    parameter int unsigned WORD_W     = DefWordW,
    parameter int unsigned ELEM_W     = DefElemW,
    parameter int unsigned FILT_ELEMS = DefFiltElems
) (
    input  logic              clk,
    input  logic              rstN,
    input  logic              clr,
    input  logic              wrEn,
    input  logic [WORD_W-1:0] wrData,
    output logic              full,
    input  logic              rdEn,
    input  logic              rdRestart,
    input  logic              rdRelease,
    output logic [ELEM_W-1:0] rdData,
    output logic              rdValid,
    output logic              rdLast,
    output logic              ready
);

    localparam int unsigned WORDS  = words_per_filter(WORD_W, ELEM_W, FILT_ELEMS);
    localparam int unsigned PTR_W  = (FILT_ELEMS > 1) ? $clog2(FILT_ELEMS) : 1;
    localparam int unsigned WPTR_W = (WORDS > 1) ? $clog2(WORDS) : 1;
`ifdef FILTER_STREAM_BUFFER_PINGPONG_EN
    localparam int unsigned NUM_BANKS = 2;
`else
    localparam int unsigned NUM_BANKS = 1;
`endif
    localparam logic [PTR_W-1:0]  LAST_ELEM = PTR_W'(FILT_ELEMS - 1);
    localparam logic [WPTR_W-1:0] LAST_WORD = WPTR_W'(WORDS - 1);

    if (WORDS < 1 || ((FILT_ELEMS * ELEM_W) % WORD_W) != 0) begin : g_cfg_check
        $error("filter_stream_buffer: FILT_ELEMS*ELEM_W must be a non-zero multiple of WORD_W");
    end

    bank_state_e       state_q [NUM_BANKS];
    bank_state_e       state_d [NUM_BANKS];
    logic [WPTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [ELEM_W-1:0] rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic              rd_last_q, rd_last_d;

    logic              wr_sel, rd_sel;
    logic              wr_accept, wr_done, rd_accept, rel_accept;
    logic [ELEM_W-1:0] bank_elem [NUM_BANKS];
    logic [ELEM_W-1:0] rd_elem;

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        filter_bank #(
            .WORD_W     (WORD_W),
            .ELEM_W     (ELEM_W),
            .FILT_ELEMS (FILT_ELEMS),
            .WORDS      (WORDS),
            .WPTR_W     (WPTR_W),
            .PTR_W      (PTR_W)
        ) u_bank (
            .clk_i     (clk),
            .wr_en_i   (wr_accept && (wr_sel == 1'(b))),
            .wr_addr_i (wr_ptr_q),
            .wr_data_i (wrData),
            .rd_ptr_i  (rd_ptr_q),
            .rd_elem_o (bank_elem[b])
        );
    end

    assign rd_elem = bank_elem[rd_sel];
    assign ready   = (state_q[rd_sel] == BankLoaded);

`ifdef FILTER_STREAM_BUFFER_PINGPONG_EN
    logic wr_bank_q, wr_bank_d;
    logic rd_bank_q, rd_bank_d;

    // Write side moves on once a bank is loaded; read side once the consumer releases.
    always_comb begin
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        if (wr_done) begin
            wr_bank_d = ~wr_bank_q;
        end
        if (rel_accept) begin
            rd_bank_d = ~rd_bank_q;
        end
        if (clr) begin
            wr_bank_d = 1'b0;
            rd_bank_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
        end else begin
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
        end
    end

    assign wr_sel = wr_bank_q;
    assign rd_sel = rd_bank_q;
    assign full   = (state_q[0] == BankLoaded) && (state_q[1] == BankLoaded);
`else
    assign wr_sel = 1'b0;
    assign rd_sel = 1'b0;
    assign full   = (state_q[0] == BankLoaded);
`endif

    always_comb begin
        wr_accept  = wrEn && (state_q[wr_sel] != BankLoaded);
        wr_done    = wr_accept && (wr_ptr_q == LAST_WORD);
        rd_accept  = rdEn && ready && !rdRestart;
        rel_accept = rdRelease && ready;
    end

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = rd_accept;
        rd_last_d  = rd_accept && (rd_ptr_q == LAST_ELEM);

        if (wr_accept) begin
            wr_ptr_d         = wr_done ? '0 : wr_ptr_q + 1'b1;
            state_d[wr_sel]  = wr_done ? BankLoaded : BankFilling;
        end

        if (rdRestart) begin
            rd_ptr_d = '0;
        end else if (rd_accept) begin
            rd_ptr_d  = (rd_ptr_q == LAST_ELEM) ? '0 : rd_ptr_q + 1'b1;
            rd_data_d = rd_elem;
        end

        // A read in the same cycle still outputs its element; the release only rewinds after it.
        if (rel_accept) begin
            rd_ptr_d        = '0;
            state_d[rd_sel] = BankEmpty;
        end

        if (clr) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                state_d[b] = BankEmpty;
            end
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            rd_data_d  = '0;
            rd_valid_d = 1'b0;
            rd_last_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                state_q[b] <= BankEmpty;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            rd_last_q  <= rd_last_d;
        end
    end

    assign rdData  = rd_data_q;
    assign rdValid = rd_valid_q;
    assign rdLast  = rd_last_q;

endmodule

// File: tb/tb_filter_stream_buffer.sv
// Randomised bench for filter_stream_buffer against a queue-of-filters reference model.
module tb_filter_stream_buffer;

    localparam int unsigned WORD_W     = 32;
    localparam int unsigned ELEM_W     = 8;
    localparam int unsigned FILT_ELEMS = 16;
    localparam int unsigned WORDS      = FILT_ELEMS * ELEM_W / WORD_W;
    localparam int unsigned TOT_W      = FILT_ELEMS * ELEM_W;
`ifdef FILTER_STREAM_BUFFER_PINGPONG_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    logic              clk;
    logic              rstN, clr, wrEn, rdEn, rdRestart, rdRelease;
    logic [WORD_W-1:0] wrData;
    logic              full, rdValid, rdLast, ready;
    logic [ELEM_W-1:0] rdData;

    filter_stream_buffer #(
        .WORD_W     (WORD_W),
        .ELEM_W     (ELEM_W),
        .FILT_ELEMS (FILT_ELEMS)
    ) dut (
        .clk       (clk),
        .rstN      (rstN),
        .clr       (clr),
        .wrEn      (wrEn),
        .wrData    (wrData),
        .full      (full),
        .rdEn      (rdEn),
        .rdRestart (rdRestart),
        .rdRelease (rdRelease),
        .rdData    (rdData),
        .rdValid   (rdValid),
        .rdLast    (rdLast),
        .ready     (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: loaded filters queue in read order, plus the filter being assembled.
    logic [TOT_W-1:0]  m_loaded [$];
    logic [TOT_W-1:0]  m_part;
    int unsigned       m_cnt, m_ptr;
    logic [ELEM_W-1:0] m_data;
    logic              m_valid, m_last;

    function automatic logic [ELEM_W-1:0] elem_of(input logic [TOT_W-1:0] f, input int unsigned i);
        return f[(FILT_ELEMS-1-i)*ELEM_W +: ELEM_W];
    endfunction

    task automatic model_clear();
        m_loaded.delete();
        m_part  = '0;
        m_cnt   = 0;
        m_ptr   = 0;
        m_data  = '0;
        m_valid = 1'b0;
        m_last  = 1'b0;
    endtask

    task automatic model_step();
        bit rdy;
        bit room;
        rdy  = (m_loaded.size() > 0);
        room = (m_loaded.size() < CAP);
        if (clr) begin
            model_clear();
            return;
        end
        m_valid = 1'b0;
        m_last  = 1'b0;
        if (rdRestart) begin
            m_ptr = 0;
        end else if (rdEn && rdy) begin
            m_data  = elem_of(m_loaded[0], m_ptr);
            m_valid = 1'b1;
            m_last  = (m_ptr == FILT_ELEMS - 1);
            m_ptr   = (m_ptr + 1) % FILT_ELEMS;
        end
        if (rdRelease && rdy) begin
            void'(m_loaded.pop_front());
            m_ptr = 0;
        end
        if (wrEn && room) begin
            m_part = (m_part << WORD_W) | TOT_W'(wrData);
            m_cnt++;
            if (m_cnt == WORDS) begin
                m_loaded.push_back(m_part);
                m_part = '0;
                m_cnt  = 0;
            end
        end
    endtask

    task automatic compare_outputs();
        check("full", 32'(full), 32'(m_loaded.size() == CAP));
        check("ready", 32'(ready), 32'(m_loaded.size() > 0));
        check("rdValid", 32'(rdValid), 32'(m_valid));
        check("rdLast", 32'(rdLast), 32'(m_last));
        check("rdData", 32'(rdData), 32'(m_data));
    endtask

    task automatic step(input logic we, input logic [WORD_W-1:0] wd, input logic re,
                        input logic rs, input logic rl, input logic cl);
        wrEn      = we;
        wrData    = wd;
        rdEn      = re;
        rdRestart = rs;
        rdRelease = rl;
        clr       = cl;
        @(posedge clk);
        model_step();
        #1;
        compare_outputs();
    endtask

    task automatic load_filter(input logic [7:0] base);
        for (int w = 0; w < int'(WORDS); w++) begin
            step(1'b1, {base + 8'(4*w), base + 8'(4*w+1), base + 8'(4*w+2), base + 8'(4*w+3)},
                 1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        rstN = 1'b0; clr = 1'b0; wrEn = 1'b0; wrData = '0;
        rdEn = 1'b0; rdRestart = 1'b0; rdRelease = 1'b0;
        model_clear();
        #2;
        check("rst_full", 32'(full), 32'd0);
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_valid", 32'(rdValid), 32'd0);
        check("rst_data", 32'(rdData), 32'd0);
        @(negedge clk);
        rstN = 1'b1;

        // Fill, stream all elements, wrap.
        load_filter(8'h00);
        check("fill_ready", 32'(ready), 32'd1);
        for (int i = 0; i < 16; i++) begin
            step(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
            check("seq_data", 32'(rdData), 32'(i));
            check("seq_last", 32'(rdLast), 32'(i == 15));
        end
        step(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("wrap_data", 32'(rdData), 32'h00);

        // Restart colliding with a read.
        step(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("pre_restart", 32'(rdData), 32'h04);
        step(1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0);
        check("restart_novalid", 32'(rdValid), 32'd0);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("restart_data", 32'(rdData), 32'h00);

        // Overflow write, readback, release, refill.
        step(1'b1, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
`ifndef FILTER_STREAM_BUFFER_PINGPONG_EN
        check("release_full", 32'(full), 32'd0);
        load_filter(8'h10);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("refill_first", 32'(rdData), 32'h10);
`else
        // Stream A while writing B, then release A on a final read.
        step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        load_filter(8'h20);
        for (int w = 0; w < int'(WORDS); w++) begin
            step(1'b1, {8'(8'h30 + 4*w), 8'(8'h31 + 4*w), 8'(8'h32 + 4*w), 8'(8'h33 + 4*w)},
                 1'b1, 1'b0, 1'b0, 1'b0);
        end
        check("pp_full", 32'(full), 32'd1);
        step(1'b0, '0, 1'b1, 1'b0, 1'b1, 1'b0);
        check("pp_rel_valid", 32'(rdValid), 32'd1);
        check("pp_rel_data", 32'(rdData), 32'h24);
        check("pp_ready", 32'(ready), 32'd1);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("pp_b_first", 32'(rdData), 32'h30);
`endif

        // Clear mid-fill.
        step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        load_filter(8'h40);
        step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'h50515253, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h54555657, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("clr_ready", 32'(ready), 32'd0);
        load_filter(8'h60);
        for (int i = 0; i < 16; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);

        // Random traffic.
        for (int c = 0; c < 1500; c++) begin
            step(1'($urandom_range(0, 99) < 50), $urandom, 1'($urandom_range(0, 99) < 70),
                 1'($urandom_range(0, 99) < 5), 1'($urandom_range(0, 99) < 6),
                 1'($urandom_range(0, 199) < 2));
        end

        // Asynchronous reset mid-operation.
        @(posedge clk);
        #3;
        rstN = 1'b0;
        #1;
        check("arst_ready", 32'(ready), 32'd0);
        check("arst_full", 32'(full), 32'd0);
        check("arst_valid", 32'(rdValid), 32'd0);
        check("arst_data", 32'(rdData), 32'd0);
        model_clear();
        @(negedge clk);
        rstN = 1'b1;
        for (int c = 0; c < 300; c++) begin
            step(1'($urandom_range(0, 99) < 50), $urandom, 1'($urandom_range(0, 99) < 70),
                 1'($urandom_range(0, 99) < 5), 1'($urandom_range(0, 99) < 6), 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
